// File: rtl/adc_sample_timing_gen_if.sv
// adc_sample_timing_gen_if
//   Control/status bus of the ADC conversion sequencer.
//   master : the controller side (drives enable and cfg_*, observes timing outputs)
//   slave  : the sequencer side
// Signals
//   enable             run request
//   cfg_period/_sync_pos/_conv_pos/_conv_len, cfg_load   programming port
//   cfg_err            sticky reject flag of the last cfg_load
//   running, cnt_o     sequencer state and phase counter
//   adc_word_sync, new_sample, adc_start_conv_en, clk_tte_o   per-period timing
//   sample_cnt         count of new_sample pulses
`timescale 1ns/1ps
interface adc_sample_timing_gen_if #(
  parameter int CNT_W  = 8,
  parameter int SCNT_W = 32
);
  logic              enable;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_sync_pos;
  logic [CNT_W-1:0]  cfg_conv_pos;
  logic [CNT_W-1:0]  cfg_conv_len;
  logic              cfg_load;
  logic              cfg_err;
  logic              running;
  logic [CNT_W-1:0]  cnt_o;
  logic              adc_word_sync;
  logic              new_sample;
  logic              adc_start_conv_en;
  logic              clk_tte_o;
  logic [SCNT_W-1:0] sample_cnt;

  modport master (
    output enable, cfg_period, cfg_sync_pos, cfg_conv_pos, cfg_conv_len, cfg_load,
    input  cfg_err, running, cnt_o, adc_word_sync, new_sample, adc_start_conv_en,
           clk_tte_o, sample_cnt
  );

  modport slave (
    input  enable, cfg_period, cfg_sync_pos, cfg_conv_pos, cfg_conv_len, cfg_load,
    output cfg_err, running, cnt_o, adc_word_sync, new_sample, adc_start_conv_en,
           clk_tte_o, sample_cnt
  );
endinterface

// File: rtl/adc_sample_timing_gen.sv
// adc_sample_timing_gen
//   Run-time programmable ADC conversion sequencer on data_clk. Each period of P
//   cycles produces a word-sync pulse, a new-sample pulse, a start-conv clock gate
//   window and a ~50% duty square wave, and counts samples. New settings are
//   staged in a pending copy and switched in only at a period wrap (or while idle),
//   so a running period is never distorted.
// Ports
//   data_clk  sole clock
//   reset     asynchronous, active-high; clears all state, cfg back to DEF_*
//   sync_in   external phase-align strobe (only when ADC_SYNC_IN_EN is defined)
//   bus       adc_sample_timing_gen_if.slave: enable, cfg_*, status and timing outputs
// Build option
//   ADC_SYNC_IN_EN : adds sync_in; a rising edge while running forces a wrap.
`timescale 1ns/1ps
module adc_sample_timing_gen #(
  parameter int CNT_W      = 8,
  parameter int SCNT_W     = 32,
  parameter int DEF_PERIOD = 20,
  parameter int DEF_SYNC   = 15,
  parameter int DEF_CONV   = 17,
  parameter int DEF_CLEN   = 2
) (
  input  logic data_clk,
  input  logic reset,
`ifdef ADC_SYNC_IN_EN
  input  logic sync_in,
`endif
  adc_sample_timing_gen_if.slave bus
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] sync_pos;
    logic [CNT_W-1:0] conv_pos;
    logic [CNT_W-1:0] conv_len;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{
    period:   CNT_W'(DEF_PERIOD),
    sync_pos: CNT_W'(DEF_SYNC),
    conv_pos: CNT_W'(DEF_CONV),
    conv_len: CNT_W'(DEF_CLEN)
  };

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  cfg_t              act, act_nxt;
  cfg_t              pend, pend_nxt;
  cfg_t              cfg_in;
  logic              cfg_err, err_nxt;
  logic              cfg_ok;
  logic              sync_edge;
  logic              clr_scnt;
  logic              run;

  logic              ws_q, ns_q, conv_q, tte_q;
  logic              ws_nxt, ns_nxt, conv_nxt, tte_nxt;
  logic [SCNT_W-1:0] scnt, scnt_nxt;

  logic [CNT_W:0]    in_conv_end;
  logic [CNT_W:0]    act_conv_end;

  // ---------------------------------------------------------------------------
  // Optional external phase align: 2-flop synchroniser plus a third flop for
  // rising-edge detection. Edge is seen two edges after sync_in rises and the
  // forced wrap lands on the third.
  // ---------------------------------------------------------------------------
`ifdef ADC_SYNC_IN_EN
  logic [2:0] sync_sr;

  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) sync_sr <= '0;
    else       sync_sr <= {sync_sr[1:0], sync_in};
  end

  assign sync_edge = sync_sr[1] & ~sync_sr[2];
`else
  assign sync_edge = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Config validation. Sums are widened by one bit so C+L cannot wrap and slip
  // past the check.
  // ---------------------------------------------------------------------------
  assign cfg_in = '{
    period:   bus.cfg_period,
    sync_pos: bus.cfg_sync_pos,
    conv_pos: bus.cfg_conv_pos,
    conv_len: bus.cfg_conv_len
  };

  assign in_conv_end  = {1'b0, cfg_in.conv_pos} + {1'b0, cfg_in.conv_len};
  assign act_conv_end = {1'b0, act.conv_pos} + {1'b0, act.conv_len};

  assign cfg_ok = (cfg_in.period >= CNT_W'(4))
               && (({1'b0, cfg_in.sync_pos} + (CNT_W+1)'(2)) <= {1'b0, cfg_in.period})
               && (cfg_in.conv_len != '0)
               && (in_conv_end <= {1'b0, cfg_in.period});

  assign run = (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    act_nxt   = act;
    err_nxt   = cfg_err;
    clr_scnt  = 1'b0;

    if (bus.cfg_load) begin
      if (cfg_ok) begin
        pend_nxt = cfg_in;
        err_nxt  = 1'b0;
      end else begin
        err_nxt  = 1'b1;
      end
    end

    case (state)
      ST_IDLE: begin
        // Idle: config follows pending every edge so the first period after
        // enable already uses the latest load.
        cnt_nxt = '0;
        act_nxt = pend_nxt;
        if (bus.enable) begin
          state_nxt = ST_RUN;
          clr_scnt  = 1'b1;
        end
      end
      ST_RUN: begin
        // Natural or forced wrap: pending (including a load in this very
        // cycle) becomes active, and a dropped enable is honoured only here so
        // the last period always completes.
        if ((cnt == act.period - CNT_W'(1)) || sync_edge) begin
          cnt_nxt = '0;
          act_nxt = pend_nxt;
          if (!bus.enable) state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Timing outputs are a registered function of the current count, so they
    // trail cnt by one cycle and are free of decode glitches.
    ws_nxt   = run && (cnt == act.sync_pos);
    ns_nxt   = run && (cnt == act.sync_pos + CNT_W'(1));
    conv_nxt = run && (cnt >= act.conv_pos) && ({1'b0, cnt} < act_conv_end);
    tte_nxt  = run && (cnt >= (act.period >> 1) - CNT_W'(1))
                   && (cnt <= act.period - CNT_W'(2));

    scnt_nxt = scnt;
    if (clr_scnt)    scnt_nxt = '0;
    else if (ns_nxt) scnt_nxt = scnt + SCNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge data_clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      act     <= DEF_CFG;
      pend    <= DEF_CFG;
      cfg_err <= 1'b0;
      ws_q    <= 1'b0;
      ns_q    <= 1'b0;
      conv_q  <= 1'b0;
      tte_q   <= 1'b0;
      scnt    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      act     <= act_nxt;
      pend    <= pend_nxt;
      cfg_err <= err_nxt;
      ws_q    <= ws_nxt;
      ns_q    <= ns_nxt;
      conv_q  <= conv_nxt;
      tte_q   <= tte_nxt;
      scnt    <= scnt_nxt;
    end
  end

  assign bus.cfg_err           = cfg_err;
  assign bus.running           = run;
  assign bus.cnt_o             = cnt;
  assign bus.adc_word_sync     = ws_q;
  assign bus.new_sample        = ns_q;
  assign bus.adc_start_conv_en = conv_q;
  assign bus.clk_tte_o         = tte_q;
  assign bus.sample_cnt        = scnt;

endmodule

// File: tb/tb_adc_sample_timing_gen.sv
`timescale 1ns/1ps
module tb_adc_sample_timing_gen;

  logic data_clk = 1'b0;
  logic reset    = 1'b1;
  logic sync_in  = 1'b0;

  int errors = 0;
  int checks = 0;

  adc_sample_timing_gen_if #(.CNT_W(8), .SCNT_W(32)) bus();

  adc_sample_timing_gen #(
    .CNT_W(8), .SCNT_W(32),
    .DEF_PERIOD(20), .DEF_SYNC(15), .DEF_CONV(17), .DEF_CLEN(2)
  ) dut (
    .data_clk (data_clk),
    .reset    (reset),
`ifdef ADC_SYNC_IN_EN
    .sync_in  (sync_in),
`endif
    .bus      (bus)
  );

  always #12.5 data_clk = ~data_clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge data_clk);
    #1;
  endtask

  task automatic wait_cnt(input int k, output int n);
    n = 0;
    while (int'(bus.cnt_o) != k && n < 200) begin
      tick();
      n++;
    end
    if (int'(bus.cnt_o) != k) chk("wait_cnt_timeout", bus.cnt_o, k);
  endtask

  task automatic load(input int p, input int s, input int c, input int l);
    bus.cfg_period   = 8'(p);
    bus.cfg_sync_pos = 8'(s);
    bus.cfg_conv_pos = 8'(c);
    bus.cfg_conv_len = 8'(l);
    bus.cfg_load     = 1'b1;
    tick();
    bus.cfg_load     = 1'b0;
  endtask

  // Starting at cnt_o==0, record one full period as observed on the outputs.
  task automatic measure(output int len, output int ws, output int ns,
                         output int cvlo, output int cvn, output int ttlo, output int ttn);
    len = 0; ws = -1; ns = -1; cvlo = -1; cvn = 0; ttlo = -1; ttn = 0;
    do begin
      if (bus.adc_word_sync) ws = int'(bus.cnt_o);
      if (bus.new_sample)    ns = int'(bus.cnt_o);
      if (bus.adc_start_conv_en) begin
        if (cvlo < 0) cvlo = int'(bus.cnt_o);
        cvn++;
      end
      if (bus.clk_tte_o) begin
        if (ttlo < 0) ttlo = int'(bus.cnt_o);
        ttn++;
      end
      len++;
      tick();
    end while (bus.cnt_o != 0 && len < 300);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, ws, ns, cvlo, cvn, ttlo, ttn, wsc;
    longint sc0;

    bus.enable = 1'b0;
    bus.cfg_load = 1'b0;
    bus.cfg_period = '0;
    bus.cfg_sync_pos = '0;
    bus.cfg_conv_pos = '0;
    bus.cfg_conv_len = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // ---- reset state ----
    chk("rst_cnt", bus.cnt_o, 0);
    chk("rst_running", bus.running, 0);
    chk("rst_ws", bus.adc_word_sync, 0);
    chk("rst_conv", bus.adc_start_conv_en, 0);
    chk("rst_tte", bus.clk_tte_o, 0);
    chk("rst_scnt", bus.sample_cnt, 0);
    chk("rst_err", bus.cfg_err, 0);

    // ---- 1: defaults ----
    bus.enable = 1'b1;
    tick();
    chk("en_running", bus.running, 1);
    chk("en_cnt", bus.cnt_o, 0);
    measure(len, ws, ns, cvlo, cvn, ttlo, ttn);
    chk("d_len", len, 20);
    chk("d_ws", ws, 16);
    chk("d_ns", ns, 17);
    chk("d_cvlo", cvlo, 18);
    chk("d_cvn", cvn, 2);
    chk("d_ttlo", ttlo, 10);
    chk("d_ttn", ttn, 10);
    chk("d_scnt1", bus.sample_cnt, 1);
    measure(len, ws, ns, cvlo, cvn, ttlo, ttn);
    chk("d_scnt2", bus.sample_cnt, 2);

    // ---- 2: reprogram mid-period ----
    wait_cnt(5, n);
    load(40, 30, 33, 4);
    chk("p40_err", bus.cfg_err, 0);
    wait_cnt(0, n);
    chk("p40_cur_rest", n, 14);
    measure(len, ws, ns, cvlo, cvn, ttlo, ttn);
    chk("p40_len", len, 40);
    chk("p40_ws", ws, 31);
    chk("p40_ns", ns, 32);
    chk("p40_cvlo", cvlo, 34);
    chk("p40_cvn", cvn, 4);
    chk("p40_ttlo", ttlo, 20);
    chk("p40_ttn", ttn, 20);

    // ---- 3: rejected loads ----
    wait_cnt(5, n);
    load(3, 1, 0, 1);
    chk("bad_p3_err", bus.cfg_err, 1);
    load(20, 15, 18, 3);
    chk("bad_cl_err", bus.cfg_err, 1);
    load(250, 10, 200, 100);
    chk("bad_ovf_err", bus.cfg_err, 1);
    load(20, 15, 17, 0);
    chk("bad_l0_err", bus.cfg_err, 1);
    wait_cnt(0, n);
    measure(len, ws, ns, cvlo, cvn, ttlo, ttn);
    chk("bad_len", len, 40);
    chk("bad_ws", ws, 31);
    chk("bad_err_sticky", bus.cfg_err, 1);
    wait_cnt(5, n);
    load(20, 15, 17, 2);
    chk("good_err_clr", bus.cfg_err, 0);
    wait_cnt(0, n);
    measure(len, ws, ns, cvlo, cvn, ttlo, ttn);
    chk("good_len", len, 20);
    chk("good_ws", ws, 16);

    // ---- minimum period, C+L==P, loaded on the wrap cycle ----
    wait_cnt(19, n);
    load(4, 1, 0, 4);
    chk("p4_err", bus.cfg_err, 0);
    chk("p4_wrap_cnt", bus.cnt_o, 0);
    measure(len, ws, ns, cvlo, cvn, ttlo, ttn);
    chk("p4_len", len, 4);
    chk("p4_ws", ws, 2);
    chk("p4_ns", ns, 3);
    chk("p4_cvlo", cvlo, 1);
    chk("p4_cvn", cvn, 3);
    chk("p4_ttlo", ttlo, 2);
    chk("p4_ttn", ttn, 2);
    measure(len, ws, ns, cvlo, cvn, ttlo, ttn);
    chk("p4b_cvlo", cvlo, 0);
    chk("p4b_cvn", cvn, 4);
    load(20, 15, 17, 2);
    wait_cnt(0, n);
    measure(len, ws, ns, cvlo, cvn, ttlo, ttn);
    chk("back20_len", len, 20);

    // ---- 4: enable drop mid-period ----
    wait_cnt(5, n);
    sc0 = longint'(bus.sample_cnt);
    bus.enable = 1'b0;
    n = 0; wsc = 0;
    do begin
      tick();
      n++;
      if (bus.adc_word_sync) wsc++;
    end while (bus.running && n < 100);
    chk("drop_ticks", n, 15);
    chk("drop_cnt", bus.cnt_o, 0);
    chk("drop_ws_seen", wsc, 1);
    chk("drop_scnt", bus.sample_cnt, sc0 + 1);
    tick(); tick();
    chk("idle_cnt", bus.cnt_o, 0);
    chk("idle_running", bus.running, 0);
    chk("idle_tte", bus.clk_tte_o, 0);
    bus.enable = 1'b1;
    tick();
    chk("reen_running", bus.running, 1);
    chk("reen_scnt", bus.sample_cnt, 0);
    chk("reen_cnt0", bus.cnt_o, 0);
    tick();
    chk("reen_cnt1", bus.cnt_o, 1);

    // ---- 5: async reset mid-period, defaults restored ----
    load(30, 20, 25, 3);
    chk("p30_err", bus.cfg_err, 0);
    load(3, 1, 0, 1);
    chk("p30_bad_err", bus.cfg_err, 1);
    wait_cnt(0, n);
    wait_cnt(17, n);
    chk("pre_rst_tte", bus.clk_tte_o, 1);
    reset = 1'b1;
    #1;
    chk("arst_cnt", bus.cnt_o, 0);
    chk("arst_running", bus.running, 0);
    chk("arst_tte", bus.clk_tte_o, 0);
    chk("arst_ns", bus.new_sample, 0);
    chk("arst_scnt", bus.sample_cnt, 0);
    chk("arst_err", bus.cfg_err, 0);
    #3;
    reset = 1'b0;
    tick();
    chk("post_rst_running", bus.running, 1);
    measure(len, ws, ns, cvlo, cvn, ttlo, ttn);
    chk("post_rst_len", len, 20);
    chk("post_rst_ws", ws, 16);
    chk("post_rst_cvlo", cvlo, 18);

`ifdef ADC_SYNC_IN_EN
    // ---- 6: external phase align ----
    wait_cnt(8, n);
    sync_in = 1'b1;
    wsc = 0;
    tick(); if (bus.adc_word_sync) wsc++;
    chk("sync_c1", bus.cnt_o, 9);
    tick(); if (bus.adc_word_sync) wsc++;
    chk("sync_c2", bus.cnt_o, 10);
    tick(); if (bus.adc_word_sync) wsc++;
    chk("sync_c3", bus.cnt_o, 0);
    chk("sync_no_ws", wsc, 0);
    sync_in = 1'b0;
    measure(len, ws, ns, cvlo, cvn, ttlo, ttn);
    chk("sync_len", len, 20);
    chk("sync_ws", ws, 16);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
